// File: rtl/operand_stage_if.sv
// Decode/execute handshake bundle for operand_stage: instruction in, ALU operands out.
// master = surrounding pipeline (decode + execute), slave = operand_stage.
interface operand_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic [DATA_WIDTH-1:0] imm;
  logic                  alusrc;
  logic                  alu_ctrl;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUop1;
  logic [DATA_WIDTH-1:0] ALUop2;
  logic                  ALUctrl;

  modport master (
    output in_valid, rs1_addr, rs2_addr, imm, alusrc, alu_ctrl, out_ready,
    input  in_ready, out_valid, ALUop1, ALUop2, ALUctrl
  );

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, imm, alusrc, alu_ctrl, out_ready,
    output in_ready, out_valid, ALUop1, ALUop2, ALUctrl
  );
endinterface

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: register file, operand-2 mux and one valid/ready slot.
// Define WB_BYPASS_EN to forward same-edge writeback data into the latched operands.
module operand_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operand_stage_if.slave        bus,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0Idx = ADDR_WIDTH'(10);

  // Register file
  logic [DATA_WIDTH-1:0] rf_q [NumRegs];
  logic                  wb_we;
  logic [DATA_WIDTH-1:0] rs1_rf;
  logic [DATA_WIDTH-1:0] rs2_rf;

  assign wb_we = wb_en && (wb_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_q <= '{default: '0};
    end else if (wb_we) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign rs1_rf = (bus.rs1_addr == '0) ? '0 : rf_q[bus.rs1_addr];
  assign rs2_rf = (bus.rs2_addr == '0) ? '0 : rf_q[bus.rs2_addr];
  assign a0     = rf_q[A0Idx];

  // Operand values presented to the slot
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;
  logic [DATA_WIDTH-1:0] op2_sel;

`ifdef WB_BYPASS_EN
  // A writeback landing on the accept edge is visible to the instruction being accepted.
  assign rs1_val = (wb_we && (wb_addr == bus.rs1_addr)) ? wb_data : rs1_rf;
  assign rs2_val = (wb_we && (wb_addr == bus.rs2_addr)) ? wb_data : rs2_rf;
`else
  assign rs1_val = rs1_rf;
  assign rs2_val = rs2_rf;
`endif

  assign op2_sel = bus.alusrc ? bus.imm : rs2_val;

  // Pipeline slot
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic                  ctrl_q, ctrl_d;
  logic                  in_ready;
  logic                  accept;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    ctrl_d      = ctrl_q;
    if (flush) begin
      // Flush wins: the held instruction dies and a same-edge accept is dropped.
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      op1_d       = rs1_val;
      op2_d       = op2_sel;
      ctrl_d      = bus.alu_ctrl;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      ctrl_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.ALUop1    = op1_q;
  assign bus.ALUop2    = op2_q;
  assign bus.ALUctrl   = ctrl_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed self-checking bench for operand_stage; expectations follow WB_BYPASS_EN when defined.
module tb_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] a0;

  int checks = 0;
  int errors = 0;

  operand_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  operand_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .flush   (flush),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .a0      (a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm, input logic src, input logic ctrl);
    bus.in_valid = 1'b1;
    bus.rs1_addr = rs1;
    bus.rs2_addr = rs2;
    bus.imm      = imm;
    bus.alusrc   = src;
    bus.alu_ctrl = ctrl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    // A writeback during reset must be dropped.
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hDEAD_BEEF;
    drive_instr(5'd1, 5'd2, 32'h55, 1'b1, 1'b1);
    step();
    step();
    wb_en = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.ALUop1 !== 32'h0) begin errors++; $display("FAIL reset_op1: got %h expected 0", bus.ALUop1); end
    checks++; if (bus.ALUop2 !== 32'h0) begin errors++; $display("FAIL reset_op2: got %h expected 0", bus.ALUop2); end
    checks++; if (bus.ALUctrl !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0", bus.ALUctrl); end
    checks++; if (a0 !== 32'h0) begin errors++; $display("FAIL reset_a0: got %h expected 0", a0); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_write_accept();
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h5;
    step();
    wb_en = 1'b0;
    checks++; if (a0 !== 32'h5) begin errors++; $display("FAIL wb_a0: got %h expected 5", a0); end
    drive_instr(5'd10, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.ALUop1 !== 32'h5) begin errors++; $display("FAIL addi_op1: got %h expected 5", bus.ALUop1); end
    checks++; if (bus.ALUop2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_op2: got %h expected ffffffff", bus.ALUop2); end
    checks++; if (bus.ALUctrl !== 1'b0) begin errors++; $display("FAIL addi_ctrl: got %b expected 0", bus.ALUctrl); end
    // Drain: valid drops, data kept.
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.ALUop1 !== 32'h5) begin errors++; $display("FAIL drain_op1: got %h expected 5", bus.ALUop1); end
  endtask

  task automatic test_x0_and_mux();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    step();
    wb_addr = 5'd7; wb_data = 32'hABCD;
    step();
    wb_en = 1'b0;
    drive_instr(5'd0, 5'd0, 32'h9999, 1'b0, 1'b1);
    step();
    checks++; if (bus.ALUop1 !== 32'h0) begin errors++; $display("FAIL x0_op1: got %h expected 0", bus.ALUop1); end
    checks++; if (bus.ALUop2 !== 32'h0) begin errors++; $display("FAIL x0_op2: got %h expected 0", bus.ALUop2); end
    checks++; if (bus.ALUctrl !== 1'b1) begin errors++; $display("FAIL bne_ctrl: got %b expected 1", bus.ALUctrl); end
    drive_instr(5'd10, 5'd7, 32'h9999, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.ALUop1 !== 32'h5) begin errors++; $display("FAIL rs2_op1: got %h expected 5", bus.ALUop1); end
    checks++; if (bus.ALUop2 !== 32'hABCD) begin errors++; $display("FAIL rs2_op2: got %h expected abcd", bus.ALUop2); end
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive_instr(5'd10, 5'd0, 32'h11, 1'b1, 1'b0);
    step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", bus.out_valid); end
    drive_instr(5'd7, 5'd0, 32'h22, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      checks++; if (bus.ALUop2 !== 32'h11 || bus.ALUop1 !== 32'h5 || bus.ALUctrl !== 1'b0 || bus.out_valid !== 1'b1)
        begin errors++; $display("FAIL bp_hold[%0d]: got op1=%h op2=%h ctrl=%b v=%b expected 5/11/0/1", i, bus.ALUop1, bus.ALUop2, bus.ALUctrl, bus.out_valid); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.ALUop1 !== 32'hABCD || bus.ALUop2 !== 32'h22 || bus.ALUctrl !== 1'b1)
      begin errors++; $display("FAIL bp_new: got op1=%h op2=%h ctrl=%b expected abcd/22/1", bus.ALUop1, bus.ALUop2, bus.ALUctrl); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive_instr(5'd10, 5'd0, 32'h33, 1'b1, 1'b0);
    step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fl_valid: got %b expected 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    flush = 1'b1;
    drive_instr(5'd7, 5'd0, 32'h44, 1'b1, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fl_in_ready: got %b expected 1", bus.in_ready); end
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_killed: got %b expected 0", bus.out_valid); end
    checks++; if (bus.ALUop2 !== 32'h33 || bus.ALUctrl !== 1'b0)
      begin errors++; $display("FAIL fl_discard: got op2=%h ctrl=%b expected 33/0", bus.ALUop2, bus.ALUctrl); end
  endtask

  task automatic test_hazard();
    logic [31:0] exp_op1;
`ifdef WB_BYPASS_EN
    exp_op1 = 32'h9;
`else
    exp_op1 = 32'h7;
`endif
    bus.out_ready = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h7;
    step();
    wb_data = 32'h9;
    drive_instr(5'd3, 5'd0, 32'h0, 1'b1, 1'b0);
    step();
    wb_en = 1'b0;
    checks++; if (bus.ALUop1 !== exp_op1) begin errors++; $display("FAIL hazard_op1: got %h expected %h", bus.ALUop1, exp_op1); end
    drive_instr(5'd3, 5'd0, 32'h0, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.ALUop1 !== 32'h9) begin errors++; $display("FAIL hazard_after: got %h expected 9", bus.ALUop1); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] imms [3];
    imms[0] = 32'h100; imms[1] = 32'h200; imms[2] = 32'h300;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_instr(5'd10, 5'd0, imms[i], 1'b1, i[0]);
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.ALUop2 !== imms[i] || bus.ALUctrl !== i[0])
        begin errors++; $display("FAIL b2b[%0d]: got v=%b op2=%h ctrl=%b expected 1/%h/%b", i, bus.out_valid, bus.ALUop2, bus.ALUctrl, imms[i], i[0]); end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", bus.out_valid); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    bus.in_valid = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0; bus.imm = '0;
    bus.alusrc = 1'b0; bus.alu_ctrl = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_accept();
    test_x0_and_mux();
    test_backpressure();
    test_flush();
    test_hazard();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
